instruction_loader: RTL and testbench

//  Writer side of the instruction-memory port: packs bytes from the UART receiver into 32-bit words.

---
 rtl/instruction_loader_pkg.sv | 18 +
 rtl/instruction_loader_word_assembler.sv | 36 +++
 rtl/instruction_loader.sv | 110 +++++++++++
 tb/tb_instruction_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, word geometry
// and the word that terminates a program load.
package instruction_loader_pkg;

  localparam int WORD_LEN       = 32;
  localparam int BYTE_LEN       = 8;
  localparam int BYTES_PER_WORD = WORD_LEN / BYTE_LEN;
  localparam logic [WORD_LEN-1:0] HALT_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Big-endian byte packer: shifts bytes into a word and flags the byte that
// completes it. The clear input drops any partial word.
module instruction_loader_word_assembler #(
  parameter int LEN    = 32,
  parameter int BYTE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_data,
  output logic [LEN-1:0]    o_word,
  output logic              o_word_valid
);

  localparam int CNT_W = $clog2(LEN / BYTE_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN / BYTE_W - 1);

  logic [CNT_W-1:0] byte_cnt;

  // Pulses alongside the final byte, so the word is complete on the next edge.
  assign o_word_valid = i_valid && !i_clear && (byte_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_word   <= '0;
      byte_cnt <= '0;
    end else if (i_clear) begin
      byte_cnt <= '0;
    end else if (i_valid) begin
      o_word   <= {o_word[LEN-BYTE_W-1:0], i_data};
      byte_cnt <= (byte_cnt == LAST_CNT) ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Packs UART bytes into words and writes them to the instruction RAM from
// address 0, holding the CPU off fetch until a HALT word is stored.
//
//   state      | meaning
//   ST_IDLE    | after reset, waiting for i_start, bytes ignored
//   ST_COLLECT | gathering bytes of the current word
//   ST_WRITE   | single-cycle RAM write of the assembled word
//   ST_DONE    | HALT stored, program ready, bytes ignored
//   ST_ERROR   | RAM filled without HALT, bytes ignored
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int             LEN       = WORD_LEN,
  parameter int             BYTE_W    = BYTE_LEN,
  parameter int             ADDR_W    = 11,
  parameter logic [LEN-1:0] HALT_WORD = HALT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addra,
  output logic [LEN-1:0]    o_dina,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [LEN-1:0]    word;
  logic              word_valid;
  logic              asm_valid;
  logic              is_halt;
  logic              at_end;

  assign is_halt = (word == HALT_WORD);
  assign at_end  = (addr_q == ADDR_MAX);

  instruction_loader_word_assembler #(
    .LEN    (LEN),
    .BYTE_W (BYTE_W)
  ) u_word_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_start),
    .i_valid      (asm_valid),
    .i_data       (i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    state_d   = state_q;
    asm_valid = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        asm_valid = i_rx_valid;
        if (word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (is_halt) begin
          state_d = ST_DONE;
        end else if (at_end) begin
          state_d = ST_ERROR;
        end else begin
          // A byte arriving alongside the write opens the next word.
          state_d   = ST_COLLECT;
          asm_valid = i_rx_valid;
        end
      end
      default: state_d = state_q;
    endcase
    if (i_start) state_d = ST_COLLECT;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_start) begin
        addr_q  <= '0;
        count_q <= '0;
      end else if (state_q == ST_WRITE) begin
        count_q <= count_q + 1'b1;
        if (state_d == ST_COLLECT) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign o_busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign o_ena        = o_busy;
  assign o_wea        = (state_q == ST_WRITE);
  assign o_addra      = addr_q;
  assign o_dina       = word;
  assign o_done       = (state_q == ST_DONE);
  assign o_error      = (state_q == ST_ERROR);
  assign o_word_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Drives a full-size loader and a 4-word loader with the same byte stream and
// compares both against a byte/word-level reference model every cycle.
module tb_instruction_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;

  logic        ena_b, wea_b, busy_b, done_b, error_b;
  logic [10:0] addra_b;
  logic [31:0] dina_b;
  logic [11:0] cnt_b;

  logic        ena_s, wea_s, busy_s, done_s, error_s;
  logic [1:0]  addra_s;
  logic [31:0] dina_s;
  logic [2:0]  cnt_s;

  int n_vec = 0;
  int n_err = 0;

  // reference model, index 0 = ADDR_W 11, index 1 = ADDR_W 2
  bit          m_active[2], m_done[2], m_err[2], m_pend[2];
  int          m_addr[2], m_cnt[2], m_nb[2], m_max[2];
  logic [31:0] m_part[2], m_wword[2];

  always #5 i_clk = ~i_clk;

  instruction_loader dut_big (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_ena        (ena_b),
    .o_wea        (wea_b),
    .o_addra      (addra_b),
    .o_dina       (dina_b),
    .o_busy       (busy_b),
    .o_done       (done_b),
    .o_error      (error_b),
    .o_word_count (cnt_b)
  );

  instruction_loader #(.ADDR_W(2)) dut_small (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_ena        (ena_s),
    .o_wea        (wea_s),
    .o_addra      (addra_s),
    .o_dina       (dina_s),
    .o_busy       (busy_s),
    .o_done       (done_s),
    .o_error      (error_s),
    .o_word_count (cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_done[k] = 0; m_err[k] = 0; m_pend[k] = 0;
      m_addr[k] = 0; m_cnt[k] = 0; m_nb[k] = 0;
      m_part[k] = '0; m_wword[k] = '0;
    end
  endtask

  task automatic model_step(input bit st, input bit v, input logic [7:0] b);
    for (int k = 0; k < 2; k++) begin
      if (st) begin
        m_active[k] = 1; m_done[k] = 0; m_err[k] = 0; m_pend[k] = 0;
        m_addr[k] = 0; m_cnt[k] = 0; m_nb[k] = 0;
      end else if (m_pend[k]) begin
        m_pend[k] = 0;
        m_cnt[k]++;
        if (m_wword[k] == HALT) begin
          m_done[k] = 1; m_active[k] = 0;
        end else if (m_addr[k] == m_max[k]) begin
          m_err[k] = 1; m_active[k] = 0;
        end else begin
          m_addr[k]++;
          if (v) begin
            m_part[k] = (m_part[k] << 8) | 32'(b);
            m_nb[k] = 1;
          end
        end
      end else if (m_active[k] && v) begin
        m_part[k] = (m_part[k] << 8) | 32'(b);
        m_nb[k]++;
        if (m_nb[k] == 4) begin
          m_nb[k] = 0;
          m_pend[k] = 1;
          m_wword[k] = m_part[k];
        end
      end
    end
  endtask

  task automatic compare(input int k);
    logic        g_ena, g_wea, g_busy, g_done, g_err;
    logic [31:0] g_addr, g_dina, g_cnt;
    string       s;
    s = (k == 0) ? "big" : "small";
    if (k == 0) begin
      g_ena = ena_b; g_wea = wea_b; g_busy = busy_b; g_done = done_b; g_err = error_b;
      g_addr = 32'(addra_b); g_dina = dina_b; g_cnt = 32'(cnt_b);
    end else begin
      g_ena = ena_s; g_wea = wea_s; g_busy = busy_s; g_done = done_s; g_err = error_s;
      g_addr = 32'(addra_s); g_dina = dina_s; g_cnt = 32'(cnt_s);
    end
    chk({s, ".wea"},   32'(g_wea),  32'(m_pend[k]));
    chk({s, ".busy"},  32'(g_busy), 32'(m_active[k]));
    chk({s, ".ena"},   32'(g_ena),  32'(m_active[k]));
    chk({s, ".done"},  32'(g_done), 32'(m_done[k]));
    chk({s, ".error"}, 32'(g_err),  32'(m_err[k]));
    chk({s, ".addra"}, g_addr,      32'(m_addr[k]));
    chk({s, ".count"}, g_cnt,       32'(m_cnt[k]));
    if (m_pend[k] || !m_active[k]) chk({s, ".dina"}, g_dina, m_wword[k]);
  endtask

  task automatic cycle(input bit st, input bit v, input logic [7:0] b);
    @(negedge i_clk);
    compare(0);
    compare(1);
    i_start    = st;
    i_rx_valid = v;
    i_rx_data  = b;
    model_step(st, v, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    cycle(0, 1, b);
    idle(int'($urandom_range(0, gap_max)));
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24], gap_max);
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rst      = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    model_reset();
    #1;
    compare(0);
    compare(1);
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    m_max[0]   = 2047;
    m_max[1]   = 3;
    i_rst      = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    idle(2);

    // first load: three words then HALT (HALT lands on the small RAM's last address)
    cycle(1, 0, 8'h00);
    send_word(32'h2001_0005, 1);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 2);
    send_word(HALT, 0);
    idle(3);

    // bytes in DONE are ignored, then a fresh load with back-to-back bytes
    send_word(32'hDEAD_BEEF, 0);
    cycle(1, 0, 8'h00);
    send_word(32'hA1A2_A3A4, 0);
    send_word(32'hB1B2_B3B4, 0);
    send_word(32'hC1C2_C3C4, 0);
    send_word(32'hD1D2_D3D4, 1);
    idle(2);
    send_word(32'hE1E2_E3E4, 0);
    send_word(HALT, 0);
    idle(2);

    // reset mid-word, bytes in IDLE, then a new load from address 0
    cycle(1, 0, 8'h00);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset();
    send_word(32'h0BAD_F00D, 0);
    cycle(1, 0, 8'h00);
    send_word(32'h1234_5678, 1);
    send_word(HALT, 1);
    idle(2);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       do_reset();
      else if (r < 8)  cycle(1, 0, 8'h00);
      else if (r < 12) send_word(HALT, int'($urandom_range(0, 1)));
      else if (r < 20) idle(int'($urandom_range(1, 3)));
      else             send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
